// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, ALU op codes
// and datapath mux select encodings.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

endpackage

// File: rtl/mc_opcode_decoder.sv
// Classifies the 6-bit opcode into one-hot instruction classes.
// Purely combinational so the debug tracer can reuse it.
module mc_opcode_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       rtype,
    output logic       lw,
    output logic       sw,
    output logic       beq,
    output logic       j,
    output logic       addi,
    output logic       illegal
);

    always_comb begin
        rtype   = 1'b0;
        lw      = 1'b0;
        sw      = 1'b0;
        beq     = 1'b0;
        j       = 1'b0;
        addi    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: rtype   = 1'b1;
            OP_LW:    lw      = 1'b1;
            OP_SW:    sw      = 1'b1;
            OP_BEQ:   beq     = 1'b1;
            OP_J:     j       = 1'b1;
            OP_ADDI:  addi    = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control sequencer: one micro-step per clock, shared memory
// port with ready handshake, retired-instruction counter and illegal-op flag.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 when memory ready
// DECODE    | read registers, precompute branch target
// MEM_ADDR  | ALUOut <= A + sign-extended imm
// MEM_READ  | load data into MDR
// MEM_WB    | rt <= MDR
// MEM_WRITE | store B to memory
// EXECUTE   | R-type ALU operation
// R_WB      | rd <= ALUOut
// BRANCH    | compare A-B, PC <= target if zero
// JUMP      | PC <= jump target
// ADDI_EX   | A + sign-extended imm
// ADDI_WB   | rt <= ALUOut
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           instr_opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal_op,
    output logic [3:0]           state_out,
    output logic [WORD_SIZE-1:0] retired_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t state, next_state;
    logic [WORD_SIZE-1:0] retired_q;

    logic is_rtype, is_lw, is_sw, is_beq, is_j, is_addi, is_illegal;
    logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, pc_write_cond_c;
    logic reg_write_c, illegal_c, retire;

    mc_opcode_decoder u_opdec (
        .opcode  (instr_opcode),
        .rtype   (is_rtype),
        .lw      (is_lw),
        .sw      (is_sw),
        .beq     (is_beq),
        .j       (is_j),
        .addi    (is_addi),
        .illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (retire)
                retired_q <= retired_q + WORD_SIZE'(1);
        end
    end

    always_comb begin
        next_state      = state;
        retire          = 1'b0;
        mem_req_c       = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        reg_write_c     = 1'b0;
        illegal_c       = 1'b0;
        i_or_d          = 1'b0;
        pc_source       = PCSRC_ALU;
        alu_src_a       = 1'b0;
        alu_src_b       = ALUB_REG;
        alu_op          = ALUOP_ADD;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = ALUB_FOUR;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH2;
                if (is_lw || is_sw)  next_state = S_MEM_ADDR;
                else if (is_rtype)   next_state = S_EXECUTE;
                else if (is_beq)     next_state = S_BRANCH;
                else if (is_j)       next_state = S_JUMP;
                else if (is_addi)    next_state = S_ADDI_EX;
                else begin
                    illegal_c  = is_illegal;
                    next_state = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                if (is_lw)      next_state = S_MEM_READ;
                else if (is_sw) next_state = S_MEM_WRITE;
                else            next_state = S_FETCH;
            end
            S_MEM_READ: begin
                mem_req_c = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALUOP_SUB;
                pc_write_cond_c = 1'b1;
                pc_source       = PCSRC_ALUOUT;
                retire          = 1'b1;
                next_state      = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_source  = PCSRC_JUMP;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_IMM;
                next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // state is already FETCH while rst is low, so only enables need masking
    assign mem_req       = mem_req_c & rst;
    assign mem_write     = mem_write_c & rst;
    assign ir_write      = ir_write_c & rst;
    assign pc_write      = pc_write_c & rst;
    assign pc_write_cond = pc_write_cond_c & rst;
    assign reg_write     = reg_write_c & rst;
    assign illegal_op    = illegal_c & rst;
    assign state_out     = state;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares on the falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       ctrl;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  instr_opcode;
    logic        mem_ready;

    logic        mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0]  state_out;
    logic [31:0] retired_count;

    logic        mem_req_w, mem_write_w, i_or_d_w, ir_write_w, pc_write_w, pc_write_cond_w;
    logic [1:0]  pc_source_w, alu_src_b_w, alu_op_w;
    logic        alu_src_a_w, reg_dst_w, mem_to_reg_w, reg_write_w, illegal_op_w;
    logic [3:0]  state_out_w;
    logic [1:0]  retired_count_w;

    ctrl_t ctrl_d, ctrl_dw;
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .state_out(state_out),
        .retired_count(retired_count)
    );

    // narrow counter copy: wraps after four retirements
    multicycle_controller #(.WORD_SIZE(2)) dut_w (
        .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .mem_ready(mem_ready),
        .mem_req(mem_req_w), .mem_write(mem_write_w), .i_or_d(i_or_d_w),
        .ir_write(ir_write_w), .pc_write(pc_write_w), .pc_write_cond(pc_write_cond_w),
        .pc_source(pc_source_w), .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w),
        .alu_op(alu_op_w), .reg_dst(reg_dst_w), .mem_to_reg(mem_to_reg_w),
        .reg_write(reg_write_w), .illegal_op(illegal_op_w), .state_out(state_out_w),
        .retired_count(retired_count_w)
    );

    assign ctrl_d  = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                      pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                      reg_write, illegal_op};
    assign ctrl_dw = {mem_req_w, mem_write_w, i_or_d_w, ir_write_w, pc_write_w, pc_write_cond_w,
                      pc_source_w, alu_src_a_w, alu_src_b_w, alu_op_w, reg_dst_w, mem_to_reg_w,
                      reg_write_w, illegal_op_w};

    function automatic ctrl_t exp_ctrl(input logic rst_v, input logic [3:0] st,
                                       input logic rdy, input logic ill);
        ctrl_t c;
        c = '0;
        if (!rst_v) begin
            c.alu_src_b = 2'b01;
            return c;
        end
        case (st)
            4'd0:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
            4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
            4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            4'd5:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            4'd9:  begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            4'd10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd11: begin c.reg_write = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic cyc(input logic rst_v, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [31:0] cnt, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = rst_v;
        instr_opcode = op;
        mem_ready    = rdy;
        e.st   = st;
        e.ctrl = exp_ctrl(rst_v, st, rdy, ill);
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",       64'(state_out),       64'(e.st));
                chk("ctrl",        64'(ctrl_d),          64'(e.ctrl));
                chk("retired",     64'(retired_count),   64'(e.cnt));
                chk("state_w",     64'(state_out_w),     64'(e.st));
                chk("ctrl_w",      64'(ctrl_dw),         64'(e.ctrl));
                chk("retired_w",   64'(retired_count_w), 64'(e.cnt[1:0]));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst          = 1'b0;
        mem_ready    = 1'b1;
        instr_opcode = R;
        repeat (3) cyc(0, R, 1, 0, 0, 0);
        // R-type: 0,1,6,7
        cyc(1, R, 1, 0, 0, 0);  cyc(1, R, 1, 1, 0, 0);
        cyc(1, R, 1, 6, 0, 0);  cyc(1, R, 1, 7, 0, 0);
        // lw with two wait cycles in MEM_READ
        cyc(1, LW, 1, 0, 1, 0); cyc(1, LW, 1, 1, 1, 0); cyc(1, LW, 1, 2, 1, 0);
        cyc(1, LW, 0, 3, 1, 0); cyc(1, LW, 0, 3, 1, 0); cyc(1, LW, 1, 3, 1, 0);
        cyc(1, LW, 1, 4, 1, 0);
        // sw, beq, j back to back
        cyc(1, SW, 1, 0, 2, 0);  cyc(1, SW, 1, 1, 2, 0);
        cyc(1, SW, 1, 2, 2, 0);  cyc(1, SW, 1, 5, 2, 0);
        cyc(1, BEQ, 1, 0, 3, 0); cyc(1, BEQ, 1, 1, 3, 0); cyc(1, BEQ, 1, 8, 3, 0);
        cyc(1, J, 1, 0, 4, 0);   cyc(1, J, 1, 1, 4, 0);   cyc(1, J, 1, 9, 4, 0);
        // illegal opcode: no retire
        cyc(1, ILL, 1, 0, 5, 0); cyc(1, ILL, 1, 1, 5, 1);
        // addi with one fetch wait cycle
        cyc(1, ADDI, 0, 0, 5, 0); cyc(1, ADDI, 1, 0, 5, 0); cyc(1, ADDI, 1, 1, 5, 0);
        cyc(1, ADDI, 1, 10, 5, 0); cyc(1, ADDI, 1, 11, 5, 0);
        // sw aborted by reset while waiting in MEM_WRITE
        cyc(1, SW, 1, 0, 6, 0);  cyc(1, SW, 1, 1, 6, 0);
        cyc(1, SW, 1, 2, 6, 0);  cyc(1, SW, 0, 5, 6, 0);
        cyc(0, SW, 1, 0, 0, 0);  cyc(0, SW, 1, 0, 0, 0);
        // restart after reset
        cyc(1, R, 1, 0, 0, 0);  cyc(1, R, 1, 1, 0, 0);
        cyc(1, R, 1, 6, 0, 0);  cyc(1, R, 1, 7, 0, 0);
        cyc(1, R, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
